reg_writeback_unit: RTL and testbench
=====================================

Name: reg_writeback_unit

Overview:
- Writer-side front end for the 32-entry, 32-bit register file. Drives the register file's single write port: write_enable, addr_3, write_data.
- Accepts writeback requests from the ALU path and the load path over valid/ready handshakes and arbitrates between them.
- Buffers accepted requests in a small in-order FIFO and retires at most one per cycle to the write port.
- Publishes a per-register pending mask so decode/hazard logic can stall on outstanding writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- XLEN, 32, data width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_ready  output  1  ALU request accepted this cycle when high together with alu_valid.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- ld_valid  input  1  load writeback request.
- ld_ready  output  1  load request accepted this cycle when high together with ld_valid.
- ld_rd  input  5  load destination register.
- ld_data  input  XLEN  load data.
- hold  input  1  freezes retirement; the write port stays idle while high.
- write_enable  output  1  to register file.
- addr_3  output  5  register file write address.
- write_data  output  XLEN  register file write data.
- pending  output  32  bit r is set while a write to register r is queued or on the write port.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-high) clears all of the following immediately, with no clock needed:
  - FIFO contents; pointers and count to 0.
  - write_enable, addr_3, write_data to 0.
  - pending to 0.
- Reset mid-operation drops every queued and in-flight write; no write_enable pulse occurs after reset asserts.
- Ready logic, from registered state only:
  - ld_ready = (count < DEPTH).
  - alu_ready = (count < DEPTH) && !ld_valid.
  - Load has fixed priority; at most one request is accepted per edge.
- Acceptance:
  - A handshake at edge E pushes {rd, data} into the FIFO at E.
  - If rd == 0, the handshake still completes but nothing is pushed; count and pending are unchanged.
- Retirement, evaluated at each edge:
  - If hold == 0 and count > 0: pop the head and load it into the output registers; write_enable = 1 for the following cycle.
  - Otherwise write_enable = 0. addr_3 and write_data keep their last values.
- Latency with an empty FIFO and hold low:
  - Accept at edge k.
  - write_enable high after edge k+1.
  - Register file commits at edge k+2.
- Throughput: one retire per cycle.
- Push and pop in the same edge leave count unchanged.
- Full FIFO: a pop at edge E does not raise ready until after E; there is no same-cycle pass-through.
- Ordering is strictly FIFO. Two queued writes to the same rd commit in acceptance order, so the last accepted value wins.
- pending[r]:
  - Equals 1 iff any valid FIFO entry has rd == r, or (write_enable == 1 and addr_3 == r).
  - Set visible after the accept edge. Cleared after the commit edge of the last outstanding write to r.
  - pending[0] is always 0.
- hold asserted while write_enable is high: the current write still completes at the next edge, and no new pop occurs at that edge.
- FIFO pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.

Test Plan:
1. Reset, hold=0, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle.
   - Expect alu_ready=1 and pending[5]=1 after the accept edge.
   - Next cycle: write_enable=1, addr_3=5, write_data=0xDEADBEEF.
   - After the commit edge: pending=0, count=0.
2. ld_valid=1 (rd=3, data=0x11111111) and alu_valid=1 (rd=4, data=0x22222222) in the same cycle.
   - Expect ld_ready=1 and alu_ready=0; reg 3 written first.
   - ALU accepted the following cycle; reg 4 written one cycle after reg 3.
3. alu_valid=1 with alu_rd=0, data=0xFFFFFFFF.
   - Expect handshake completes, count stays 0, write_enable never asserts, pending stays 0.
4. hold=1, then 5 ALU requests to rd=1..5.
   - Expect the first 4 accepted, count=4, alu_ready=0 on the 5th, pending=0x0000001E.
   - Release hold: writes 1,2,3,4 on consecutive cycles, 5th request accepted after the first pop, pending returns to 0.
5. hold=1, queue rd=7 data=0xA then rd=7 data=0xB; release hold.
   - Expect two writes in order 0xA then 0xB.
   - pending[7] stays 1 until after the second commit edge.
6. Queue 3 entries with hold=0, assert reset asynchronously mid-cycle while write_enable=1.
   - Expect write_enable, pending and count go to 0 immediately.
   - No further writes after reset deasserts.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// Writeback front end: arbitrates ALU/load requests into an in-order FIFO
// and retires one entry per cycle to the register file write port.
// Ports: clk, reset (async, active-high); alu_/ld_ valid/ready/rd/data
// request channels; hold freezes retirement; write_enable/addr_3/write_data
// drive the register file; pending is a per-register outstanding-write
// mask; count is the FIFO occupancy.
module reg_writeback_unit #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  input  logic                     hold,
  output logic                     write_enable,
  output logic [4:0]               addr_3,
  output logic [XLEN-1:0]          write_data,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            we_q, we_d;
  logic [4:0]      addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            full;
  logic            ld_fire, alu_fire;
  logic [4:0]      push_rd;
  logic [XLEN-1:0] push_data;
  logic            push, pop;

  // Readiness depends on registered occupancy only: a pop at this edge
  // cannot free a slot for a request at the same edge.
  assign full      = (count_q == CW'(DEPTH));
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;

  assign ld_fire   = ld_valid && ld_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign push_rd   = ld_fire ? ld_rd : alu_rd;
  assign push_data = ld_fire ? ld_data : alu_data;
  // x0 writes complete the handshake but are discarded.
  assign push      = (ld_fire || alu_fire) && (push_rd != 5'd0);
  assign pop       = !hold && (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    we_d    = pop;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop) begin
      rptr_d  = rptr_q + AW'(1);
      addr_d  = rd_q[rptr_q];
      wdata_d = data_q[rptr_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (push) begin
        rd_q[wptr_q]   <= push_rd;
        data_q[wptr_q] <= push_data;
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Mark every live FIFO slot plus the write currently on the port.
  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        pending[rd_q[rptr_q + AW'(k)]] = 1'b1;
      end
    end
    if (we_q) pending[addr_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign write_enable = we_q;
  assign addr_3       = addr_q;
  assign write_data   = wdata_q;
  assign count        = count_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit: per-cycle vector table plus
// hand-written hold/same-rd and asynchronous reset sequences.
module tb_reg_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        hold;
  logic        write_enable;
  logic [4:0]  addr_3;
  logic [31:0] write_data;
  logic [31:0] pending;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  reg_writeback_unit #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_data(ld_data),
    .hold(hold),
    .write_enable(write_enable), .addr_3(addr_3),
    .write_data(write_data), .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hold;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        elr;
    logic        ear;
    logic        ewe;
    logic [4:0]  eaddr;
    logic [31:0] ewd;
    logic [31:0] epend;
    logic [2:0]  ecnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vt [NV];

  function automatic vec_t mk(
    input logic h, input logic lv, input logic [4:0] lrd,
    input logic [31:0] ldat, input logic av, input logic [4:0] ard,
    input logic [31:0] adat, input logic elr, input logic ear,
    input logic ewe, input logic [4:0] eaddr, input logic [31:0] ewd,
    input logic [31:0] epend, input logic [2:0] ecnt);
    vec_t v;
    v.hold = h;     v.lv = lv;     v.lrd = lrd;   v.ldat = ldat;
    v.av = av;      v.ard = ard;   v.adat = adat;
    v.elr = elr;    v.ear = ear;   v.ewe = ewe;   v.eaddr = eaddr;
    v.ewd = ewd;    v.epend = epend; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ldat, input logic av,
                       input logic [4:0] ard, input logic [31:0] adat);
    hold = h; ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    alu_valid = av; alu_rd = ard; alu_data = adat;
  endtask

  task automatic idle(input logic h);
    drive(h, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    // Test 1: single ALU write
    vt[0]  = mk(0,0,0,0, 1,5,32'hDEADBEEF, 1,1,0,0,32'h0,        32'h0, 0);
    vt[1]  = mk(0,0,0,0, 0,0,0,            1,1,0,0,32'h0,        32'h20,1);
    vt[2]  = mk(0,0,0,0, 0,0,0,            1,1,1,5,32'hDEADBEEF, 32'h20,0);
    vt[3]  = mk(0,0,0,0, 0,0,0,            1,1,0,5,32'hDEADBEEF, 32'h0, 0);
    // Test 2: load priority over ALU
    vt[4]  = mk(0,1,3,32'h11111111, 1,4,32'h22222222,
                1,0,0,5,32'hDEADBEEF, 32'h0, 0);
    vt[5]  = mk(0,0,0,0, 1,4,32'h22222222,
                1,1,0,5,32'hDEADBEEF, 32'h08,1);
    vt[6]  = mk(0,0,0,0, 0,0,0, 1,1,1,3,32'h11111111, 32'h18,1);
    vt[7]  = mk(0,0,0,0, 0,0,0, 1,1,1,4,32'h22222222, 32'h10,0);
    vt[8]  = mk(0,0,0,0, 0,0,0, 1,1,0,4,32'h22222222, 32'h0, 0);
    // Test 3: x0 write dropped
    vt[9]  = mk(0,0,0,0, 1,0,32'hFFFFFFFF, 1,1,0,4,32'h22222222, 32'h0,0);
    vt[10] = mk(0,0,0,0, 0,0,0,            1,1,0,4,32'h22222222, 32'h0,0);
    vt[11] = mk(0,0,0,0, 0,0,0,            1,1,0,4,32'h22222222, 32'h0,0);
    // Test 4: fill under hold, then drain
    vt[12] = mk(1,0,0,0, 1,1,32'h101, 1,1,0,4,32'h22222222, 32'h00,0);
    vt[13] = mk(1,0,0,0, 1,2,32'h102, 1,1,0,4,32'h22222222, 32'h02,1);
    vt[14] = mk(1,0,0,0, 1,3,32'h103, 1,1,0,4,32'h22222222, 32'h06,2);
    vt[15] = mk(1,0,0,0, 1,4,32'h104, 1,1,0,4,32'h22222222, 32'h0E,3);
    vt[16] = mk(1,0,0,0, 1,5,32'h105, 0,0,0,4,32'h22222222, 32'h1E,4);
    vt[17] = mk(0,0,0,0, 1,5,32'h105, 0,0,0,4,32'h22222222, 32'h1E,4);
    vt[18] = mk(0,0,0,0, 1,5,32'h105, 1,1,1,1,32'h101,      32'h1E,3);
    vt[19] = mk(0,0,0,0, 0,0,0,       1,1,1,2,32'h102,      32'h3C,3);
    vt[20] = mk(0,0,0,0, 0,0,0,       1,1,1,3,32'h103,      32'h38,2);
    vt[21] = mk(0,0,0,0, 0,0,0,       1,1,1,4,32'h104,      32'h30,1);
    vt[22] = mk(0,0,0,0, 0,0,0,       1,1,1,5,32'h105,      32'h20,0);
    vt[23] = mk(0,0,0,0, 0,0,0,       1,1,0,5,32'h105,      32'h00,0);

    reset = 1'b1;
    idle(1'b0);
    #2;
    chk("rst_we",    0, 32'(write_enable), 32'h0);
    chk("rst_pend",  0, pending,           32'h0);
    chk("rst_cnt",   0, 32'(count),        32'h0);
    chk("rst_addr",  0, 32'(addr_3),       32'h0);
    chk("rst_wdata", 0, write_data,        32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].hold, vt[i].lv, vt[i].lrd, vt[i].ldat,
            vt[i].av, vt[i].ard, vt[i].adat);
      #1;
      chk("ld_ready",  i, 32'(ld_ready),     32'(vt[i].elr));
      chk("alu_ready", i, 32'(alu_ready),    32'(vt[i].ear));
      chk("we",        i, 32'(write_enable), 32'(vt[i].ewe));
      chk("addr",      i, 32'(addr_3),       32'(vt[i].eaddr));
      chk("wdata",     i, write_data,        vt[i].ewd);
      chk("pending",   i, pending,           vt[i].epend);
      chk("count",     i, 32'(count),        32'(vt[i].ecnt));
      @(negedge clk);
    end

    // Test 5: same rd twice; hold raised while a write is on the port
    drive(1, 0, 0, 0, 1, 7, 32'hA);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 7, 32'hB);
    #1;
    chk("t5_pend", 1, pending, 32'h80);
    chk("t5_cnt",  1, 32'(count), 32'h1);
    @(negedge clk);
    idle(1'b0);
    #1;
    chk("t5_cnt",  2, 32'(count), 32'h2);
    chk("t5_we",   2, 32'(write_enable), 32'h0);
    @(negedge clk);
    idle(1'b1);
    #1;
    chk("t5_we",   3, 32'(write_enable), 32'h1);
    chk("t5_addr", 3, 32'(addr_3), 32'h7);
    chk("t5_wd",   3, write_data, 32'hA);
    chk("t5_pend", 3, pending, 32'h80);
    @(negedge clk);
    idle(1'b0);
    #1;
    chk("t5_we",   4, 32'(write_enable), 32'h0);
    chk("t5_wd",   4, write_data, 32'hA);
    chk("t5_cnt",  4, 32'(count), 32'h1);
    chk("t5_pend", 4, pending, 32'h80);
    @(negedge clk);
    #1;
    chk("t5_we",   5, 32'(write_enable), 32'h1);
    chk("t5_wd",   5, write_data, 32'hB);
    chk("t5_pend", 5, pending, 32'h80);
    chk("t5_cnt",  5, 32'(count), 32'h0);
    @(negedge clk);
    #1;
    chk("t5_we",   6, 32'(write_enable), 32'h0);
    chk("t5_pend", 6, pending, 32'h0);
    @(negedge clk);

    // Test 6: asynchronous reset while a write is on the port
    drive(0, 0, 0, 0, 1, 10, 32'hA0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 11, 32'hB0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 12, 32'hC0);
    @(negedge clk);
    idle(1'b0);
    #1;
    chk("t6_we_pre",  0, 32'(write_enable), 32'h1);
    chk("t6_cnt_pre", 0, 32'(count), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_we",   0, 32'(write_enable), 32'h0);
    chk("t6_pend", 0, pending, 32'h0);
    chk("t6_cnt",  0, 32'(count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t6_post_we",   c, 32'(write_enable), 32'h0);
      chk("t6_post_pend", c, pending, 32'h0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
